// File: rtl/dca_lsu_outstanding_tracker.sv
// Outstanding-burst tracker for the DCA matrix LSU read path: in-order tag FIFO plus occupancy.
// Optional sticky error flag enabled by defining DCA_TRACKER_ERROR_CHECK_EN.
module dca_lsu_outstanding_tracker #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BW_BURDEN = 1,
  localparam int unsigned BW_COUNT = $clog2(DEPTH + 1),
  localparam int unsigned BW_PTR   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rstnn,
  input  logic                 clear,
  input  logic                 enable,
  output logic                 req_allow,
  input  logic                 req_valid,
  input  logic                 req_ready,
  input  logic                 req_last,
  input  logic [BW_BURDEN-1:0] req_burden,
  input  logic                 rsp_stall,
  input  logic                 rsp_yvalid,
  input  logic                 rsp_ylast,
  output logic [1:0]           rsp_yready,
  output logic [BW_BURDEN-1:0] rsp_burden,
  output logic                 rsp_done,
`ifdef DCA_TRACKER_ERROR_CHECK_EN
  output logic                 err_flag,
  input  logic                 err_clear,
`endif
  output logic                 busy,
  output logic [BW_COUNT-1:0]  count
);

  logic [BW_BURDEN-1:0] mem [DEPTH];
  logic [BW_PTR-1:0]    rptr_q, rptr_d;
  logic [BW_PTR-1:0]    wptr_q, wptr_d;
  logic [BW_COUNT-1:0]  count_q, count_d;

  logic full, empty, push_hs, push, pop, do_push;

  function automatic logic [BW_PTR-1:0] ptr_inc(input logic [BW_PTR-1:0] ptr);
    // Explicit wrap so non-power-of-two depths work.
    if (ptr == BW_PTR'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + BW_PTR'(1);
  endfunction

  always_comb begin
    full          = (count_q == BW_COUNT'(DEPTH));
    empty         = (count_q == '0);
    rsp_yready    = {1'b0, ~rsp_stall & ~empty};
    pop           = rsp_yvalid & rsp_yready[0] & rsp_ylast;
    push_hs       = req_valid & req_ready & req_last;
    push          = push_hs & (~full | pop);
    req_allow     = ~full | pop;
    rsp_done      = pop;
    rsp_burden    = mem[rptr_q];
    busy          = ~empty;
    count         = count_q;
  end

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    do_push = 1'b0;
    if (clear) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else if (enable) begin
      do_push = push;
      if (push) begin
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      count_d = count_q + BW_COUNT'(push) - BW_COUNT'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Tag storage carries no reset; contents are only read while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= req_burden;
    end
  end

`ifdef DCA_TRACKER_ERROR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (clear || err_clear) begin
      err_d = 1'b0;
    end else if ((push_hs & full & ~pop & enable) |
                 (rsp_yvalid & rsp_ylast & ~rsp_stall & empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flag = err_q;
`endif

endmodule

// File: tb/tb_dca_lsu_outstanding_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based tag model.
module tb_dca_lsu_outstanding_tracker;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BW    = 2;

  logic          clk = 1'b0;
  logic          rstnn = 1'b0;
  logic          clear = 1'b0, enable = 1'b1;
  logic          req_valid = 1'b0, req_ready = 1'b0, req_last = 1'b0;
  logic [BW-1:0] req_burden = '0;
  logic          rsp_stall = 1'b0, rsp_yvalid = 1'b0, rsp_ylast = 1'b0;
  logic          req_allow, rsp_done, busy;
  logic [1:0]    rsp_yready;
  logic [BW-1:0] rsp_burden;
  logic [2:0]    count;
`ifdef DCA_TRACKER_ERROR_CHECK_EN
  logic          err_flag;
  logic          err_clear = 1'b0;
  logic          exp_err = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [BW-1:0] q[$];

  dca_lsu_outstanding_tracker #(.DEPTH(DEPTH), .BW_BURDEN(BW)) dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable), .req_allow(req_allow),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_burden(req_burden), .rsp_stall(rsp_stall), .rsp_yvalid(rsp_yvalid),
    .rsp_ylast(rsp_ylast), .rsp_yready(rsp_yready), .rsp_burden(rsp_burden),
    .rsp_done(rsp_done),
`ifdef DCA_TRACKER_ERROR_CHECK_EN
    .err_flag(err_flag), .err_clear(err_clear),
`endif
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pv, input bit pr, input bit pl, input logic [BW-1:0] tag,
                       input bit rv, input bit rl, input bit st, input bit en, input bit cl);
    req_valid = pv; req_ready = pr; req_last = pl; req_burden = tag;
    rsp_yvalid = rv; rsp_ylast = rl; rsp_stall = st; enable = en; clear = cl;
  endtask

  // Check outputs against the model mid-cycle, then clock and advance the model.
  task automatic cycle();
    bit full, empty, rdy, pop, push_hs;
    #1;
    full    = (q.size() == DEPTH);
    empty   = (q.size() == 0);
    rdy     = !rsp_stall && !empty;
    pop     = rsp_yvalid && rsp_ylast && rdy;
    push_hs = req_valid && req_ready && req_last;
    chk("count", 32'(count), 32'(q.size()));
    chk("busy", 32'(busy), 32'(!empty));
    chk("rsp_yready", 32'(rsp_yready), {31'b0, rdy});
    chk("rsp_done", 32'(rsp_done), 32'(pop));
    chk("req_allow", 32'(req_allow), 32'(!full || pop));
    if (!empty) chk("rsp_burden", 32'(rsp_burden), 32'(q[0]));
`ifdef DCA_TRACKER_ERROR_CHECK_EN
    chk("err_flag", 32'(err_flag), 32'(exp_err));
`endif
    @(posedge clk);
`ifdef DCA_TRACKER_ERROR_CHECK_EN
    if (clear || err_clear) exp_err = 1'b0;
    else if ((push_hs && full && !pop && enable) ||
             (rsp_yvalid && rsp_ylast && !rsp_stall && empty)) exp_err = 1'b1;
`endif
    if (clear) begin
      q.delete();
    end else if (enable) begin
      if (pop) void'(q.pop_front());
      if (push_hs && (!full || pop)) q.push_back(req_burden);
    end
    #1;
  endtask

  task automatic push_tag(input logic [BW-1:0] tag);
    drive(1, 1, 1, tag, 0, 0, 0, 1, 0);
    cycle();
  endtask

  task automatic pop_one();
    drive(0, 0, 0, '0, 1, 1, 0, 1, 0);
    cycle();
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, 0, 0, 1, 0);
    #12 rstnn = 1'b1;
    @(posedge clk); #1;
    cycle();
    chk("idle_count", 32'(count), 0);
    chk("idle_yready", 32'(rsp_yready), 0);
    chk("idle_allow", 32'(req_allow), 1);

    // Basic push/pop order.
    push_tag(2'd1); push_tag(2'd2); push_tag(2'd3);
    chk("three_count", 32'(count), 3);
    repeat (3) pop_one();
    chk("drained_busy", 32'(busy), 0);

    // Fill, dropped push while full, drain.
    for (int i = 0; i < 4; i++) push_tag(2'(i));
    chk("full_count", 32'(count), 4);
    chk("full_allow", 32'(req_allow), 0);
    push_tag(2'd2);
    chk("drop_count", 32'(count), 4);
    chk("drop_head", 32'(rsp_burden), 0);
    repeat (4) pop_one();

    // Full with simultaneous push/pop, then continuous wrap traffic.
    for (int i = 0; i < 4; i++) push_tag(2'(i));
    drive(1, 1, 1, 2'd3, 1, 1, 0, 1, 0);
    cycle();
    chk("swap_count", 32'(count), 4);
    chk("swap_head", 32'(rsp_burden), 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 2'($urandom), 1, 1, 0, 1, 0);
      cycle();
    end
    repeat (4) pop_one();

    // Stall holds responses off.
    push_tag(2'd2); push_tag(2'd1);
    repeat (3) begin
      drive(0, 0, 0, '0, 1, 1, 1, 1, 0);
      cycle();
    end
    chk("stall_count", 32'(count), 2);
    drive(0, 0, 0, '0, 1, 0, 0, 1, 0);
    cycle();
    repeat (2) pop_one();

    // Enable low holds; clear flushes even with enable low.
    push_tag(2'd0); push_tag(2'd1); push_tag(2'd2);
    repeat (2) begin
      drive(1, 1, 1, 2'd3, 1, 1, 0, 0, 0);
      cycle();
    end
    chk("hold_count", 32'(count), 3);
    drive(1, 1, 1, 2'd3, 1, 1, 0, 0, 1);
    cycle();
    chk("clear_count", 32'(count), 0);

    // Asynchronous reset mid-burst.
    push_tag(2'd3); push_tag(2'd2);
    drive(0, 0, 0, '0, 1, 0, 0, 1, 0);
    #1 rstnn = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_yready", 32'(rsp_yready), 0);
    q.delete();
`ifdef DCA_TRACKER_ERROR_CHECK_EN
    exp_err = 1'b0;
`endif
    #1 rstnn = 1'b1;
    @(posedge clk); #1;
    drive(0, 0, 0, '0, 1, 1, 0, 1, 0);
    cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            2'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
`ifdef DCA_TRACKER_ERROR_CHECK_EN
      err_clear = ($urandom_range(0, 19) == 0);
`endif
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dca_lsu_outstanding_tracker.md
Name: dca_lsu_outstanding_tracker

Overview:
- Parametrised outstanding-transaction tracker for the DCA matrix LSU read path.
- Counts completed request bursts on the LPI/AXI request side and records each burst's burden tag in an in-order FIFO.
- Opens the response ready only while at least one burst is outstanding.
- When a response burst completes, returns the tag stored for it, so tags no longer ride in the response data.

Parameters:
- DEPTH, 4, maximum outstanding bursts; any integer >= 1 (not restricted to powers of two).
- BW_BURDEN, 1, width of the burden tag stored per burst; >= 1.
- BW_COUNT, $clog2(DEPTH+1), width of the occupancy count (localparam).
- BW_PTR, (DEPTH>1) ? $clog2(DEPTH) : 1, FIFO pointer width (localparam).

Ports:
- clk  input  1  clock, all state on rising edge
- rstnn  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of all tracking state
- enable  input  1  when 0, tracking state holds
- req_allow  output  1  1 when a new burst may be issued (not full)
- req_valid  input  1  observed request valid
- req_ready  input  1  observed request ready
- req_last  input  1  observed request last beat
- req_burden  input  BW_BURDEN  tag captured with the burst
- rsp_stall  input  1  consumer back-pressure; forces response ready low
- rsp_yvalid  input  1  response beat valid
- rsp_ylast  input  1  response last beat of burst
- rsp_yready  output  2  bit0 = response ready; bit1 tied 0
- rsp_burden  output  BW_BURDEN  tag of the oldest outstanding burst
- rsp_done  output  1  pulse: burst completed this cycle
- busy  output  1  count != 0
- count  output  BW_COUNT  number of outstanding bursts

Behaviour:
- Reset (rstnn=0, asynchronous): rptr=0, wptr=0, count=0; tag storage is not reset.
- Reset output values: req_allow=1, rsp_yready=2'b00, rsp_done=0, busy=0, count=0, rsp_burden=X (don't-care while empty).
- full = (count==DEPTH); empty = (count==0).
- req_allow = ~full | pop.
- push_hs = req_valid & req_ready & req_last.
- rsp_yready[0] = ~rsp_stall & ~empty, combinational; rsp_yready[1]=0.
- pop = rsp_yvalid & rsp_yready[0] & rsp_ylast.
- rsp_done = pop, combinational, no registered latency.
- Next-state priority each rising edge, first match wins:
  1. clear=1: rptr, wptr, count <= 0; push/pop ignored, even if enable=0.
  2. enable=0: all state holds.
  3. Otherwise: push = push_hs & (~full | pop).
    - push: mem[wptr] <= req_burden; wptr advances.
    - pop: rptr advances.
    - count <= count + push - pop.
- Pointer wrap: DEPTH-1 -> 0, explicit compare (not a power-of-two mask).
- Simultaneous push and pop:
  - count unchanged.
  - Legal when full: the popped slot is reused.
  - When count==1, rsp_burden shows the old head this cycle and the new tag next cycle.
- Push handshake while full without a pop: the push is dropped and state is unchanged. Upstream must honour req_allow.
- rsp_burden = mem[rptr], combinational, valid whenever ~empty.
- Non-last beats (req_last=0 or rsp_ylast=0) never change state.
- Reset asserted mid-burst discards everything. After release, response beats of a lost burst see rsp_yready[0]=0.

Optional Feature:
- Macro: DCA_TRACKER_ERROR_CHECK_EN.
- With the macro:
  - Adds output err_flag (1 bit) and input err_clear (1 bit).
  - err_flag is sticky; it sets on a dropped push (push_hs & full & ~pop & enable & ~clear).
  - It also sets on rsp_yvalid & rsp_ylast & ~rsp_stall while empty (orphan response).
  - err_clear or clear resets it synchronously; reset value 0.
- Without the macro: these ports and the logic do not exist. Dropped pushes are silent.

Test Plan (DEPTH=4, BW_BURDEN=2):
- Reset, then idle -> count=0, busy=0, rsp_yready=2'b00, req_allow=1.
- Push tags 1,2,3 (last beats), then pop 3 bursts -> count 1,2,3 then 2,1,0; rsp_burden sequence 1,2,3; rsp_done one pulse per pop; busy falls after the third pop.
- Fill with 0,1,2,3 -> count=4, req_allow=0. Fifth push (tag 2) without pop -> dropped, count=4, err_flag=1 if macro on. Pop all -> tags 0,1,2,3.
- Full, simultaneous push (tag 3) and pop -> count stays 4; later pops yield 1,2,3,3. Wraps pointers over 10 cycles continuously.
- rsp_stall=1 with count=2 and rsp_yvalid/ylast=1 -> rsp_yready[0]=0, count stays 2. Release stall -> one pop per last beat.
- enable=0 with push and pop handshakes -> state holds. clear=1 with count=3 -> count=0 next cycle. rstnn pulse mid-burst -> immediate count=0, rsp_yready=0 without a clock edge.
